// File: rtl/dispatch_source_pkg.sv
// Configuration packages for the dispatch-mode source side.
// network_config holds the network geometry. source_config derives the source-word
// width from it and declares the decoder state type.

package network_config;
   localparam int unsigned NET_NUM_INP = 4;
endpackage

package source_config;
   import network_config::*;

   // Wide enough to carry a count in 0..NET_NUM_INP and any index in 0..NET_NUM_INP-1.
   localparam int unsigned SRC_WIDTH = $clog2(NET_NUM_INP + 1);

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      PRESENT
   } src_state_t;
endpackage

// File: rtl/dispatch_source.sv
// dispatch_source: decodes one count word K and then K index words into a single fire
// vector. It presents that vector to the network's net_inp handshake. While the vector
// is presented, no new source word is accepted, so consecutive packets never overlap.

module dispatch_source
   import network_config::*;
   import source_config::*;
(
   input  logic                   clk,
   input  logic                   arstn,
   input  logic                   clr,
   input  logic                   src_valid,
   output logic                   src_ready,
   input  logic [SRC_WIDTH-1:0]   src,
   output logic                   net_valid,
   input  logic                   net_ready,
   output logic [NET_NUM_INP-1:0] net_inp,
   output logic                   err
);

   localparam logic [SRC_WIDTH-1:0] NUM_INP_W = SRC_WIDTH'(NET_NUM_INP);
   localparam logic [SRC_WIDTH-1:0] ONE_W     = SRC_WIDTH'(1);

   src_state_t             r_state;
   logic [SRC_WIDTH-1:0]   r_remaining;
   logic [NET_NUM_INP-1:0] r_vec;
   logic                   r_err;

   logic                   w_src_fire;
   logic                   w_net_fire;
   logic                   w_count_over;
   logic [SRC_WIDTH-1:0]   w_count;
   logic                   w_idx_ok;
   logic [NET_NUM_INP-1:0] w_idx_onehot;

   assign src_ready  = (r_state != PRESENT);
   assign net_valid  = (r_state == PRESENT);
   assign net_inp    = r_vec;
   assign err        = r_err;

   assign w_src_fire = src_valid && src_ready;
   assign w_net_fire = net_valid && net_ready;

   // Clamp oversized counts to the number of network inputs.
   assign w_count_over = (src > NUM_INP_W);
   assign w_count      = w_count_over ? NUM_INP_W : src;
   assign w_idx_ok     = (src < NUM_INP_W);

   // Decode an in-range index word into a one-hot bit. Out-of-range indices decode to zero.
   always_comb begin
      w_idx_onehot = '0;
      for (int i = 0; i < NET_NUM_INP; i++) begin
         w_idx_onehot[i] = w_idx_ok && (src == SRC_WIDTH'(i));
      end
   end

   // Packet decoder FSM. It owns the vector, the remaining-word counter and the sticky error flag.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         r_state     <= IDLE;
         r_remaining <= '0;
         r_vec       <= '0;
         r_err       <= 1'b0;
      end else if (clr) begin
         // clr beats any handshake in the same cycle.
         r_state     <= IDLE;
         r_remaining <= '0;
         r_vec       <= '0;
         r_err       <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_src_fire) begin
                  if (w_count_over) begin
                     r_err <= 1'b1;
                  end
                  if (w_count == '0) begin
                     r_vec   <= '0;
                     r_state <= PRESENT;
                  end else begin
                     r_remaining <= w_count;
                     r_state     <= COLLECT;
                  end
               end
            end

            COLLECT: begin
               if (w_src_fire) begin
                  // Duplicate indices OR in, so repeating an index has no further effect.
                  r_vec <= r_vec | w_idx_onehot;
                  if (!w_idx_ok) begin
                     r_err <= 1'b1;
                  end
                  if (r_remaining != '0) begin
                     r_remaining <= r_remaining - ONE_W;
                  end
                  if (r_remaining <= ONE_W) begin
                     r_state <= PRESENT;
                  end
               end
            end

            PRESENT: begin
               if (w_net_fire) begin
                  r_vec   <= '0;
                  r_state <= IDLE;
               end
            end

            default: begin
               r_state     <= IDLE;
               r_remaining <= '0;
               r_vec       <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dispatch_source.sv
// Testbench for dispatch_source. It uses a packet-level reference model, a per-cycle
// comparison against that model, and directed scenarios with literal expectations.

module tb_dispatch_source;
   import network_config::*;
   import source_config::*;

   logic                   clk = 1'b0;
   logic                   arstn = 1'b0;
   logic                   clr = 1'b0;
   logic                   src_valid = 1'b0;
   logic                   src_ready;
   logic [SRC_WIDTH-1:0]   src = '0;
   logic                   net_valid;
   logic                   net_ready = 1'b1;
   logic [NET_NUM_INP-1:0] net_inp;
   logic                   err;

   int total = 0;
   int bad   = 0;
   bit cmp_en = 1'b0;

   dispatch_source u_dut (
      .clk       (clk),
      .arstn     (arstn),
      .clr       (clr),
      .src_valid (src_valid),
      .src_ready (src_ready),
      .src       (src),
      .net_valid (net_valid),
      .net_ready (net_ready),
      .net_inp   (net_inp),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Reference model: expecting a count, collecting indices, or presenting a vector.
   bit                     m_collect = 1'b0;
   bit                     m_pres    = 1'b0;
   bit                     m_err     = 1'b0;
   int                     m_left    = 0;
   logic [NET_NUM_INP-1:0] m_vec     = '0;

   always @(posedge clk or negedge arstn) begin
      int k;
      if (!arstn || clr) begin
         m_collect = 1'b0;
         m_pres    = 1'b0;
         m_err     = 1'b0;
         m_left    = 0;
         m_vec     = '0;
      end else if (m_pres) begin
         if (net_ready) begin
            m_pres = 1'b0;
            m_vec  = '0;
         end
      end else if (src_valid) begin
         if (!m_collect) begin
            if (int'(src) > NET_NUM_INP) begin
               m_err = 1'b1;
               k     = NET_NUM_INP;
            end else begin
               k = int'(src);
            end
            if (k == 0) begin
               m_pres = 1'b1;
            end else begin
               m_left    = k;
               m_collect = 1'b1;
            end
         end else begin
            if (int'(src) < NET_NUM_INP) m_vec[src] = 1'b1;
            else m_err = 1'b1;
            m_left = m_left - 1;
            if (m_left == 0) begin
               m_collect = 1'b0;
               m_pres    = 1'b1;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare the DUT against the model on every cycle.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("cmp_src_ready", 32'(src_ready), 32'(!m_pres));
         check("cmp_net_valid", 32'(net_valid), 32'(m_pres));
         check("cmp_net_inp",   32'(net_inp),   32'(m_vec));
         check("cmp_err",       32'(err),       32'(m_err));
      end
   end

   task automatic send(input logic [SRC_WIDTH-1:0] w);
      int n = 0;
      @(negedge clk);
      while (!src_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!src_ready) check("send_timeout", 32'(src_ready), 32'd1);
      src_valid = 1'b1;
      src       = w;
      @(posedge clk);
      #1 src_valid = 1'b0;
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      clr = 1'b1;
      @(posedge clk);
      #1 clr = 1'b0;
   endtask

   initial begin
      // Reset state.
      repeat (2) @(negedge clk);
      check("rst_src_ready", 32'(src_ready), 32'd1);
      check("rst_net_valid", 32'(net_valid), 32'd0);
      check("rst_net_inp",   32'(net_inp),   32'd0);
      check("rst_err",       32'(err),       32'd0);
      arstn  = 1'b1;
      cmp_en = 1'b1;

      // Basic packet: the vector is valid for exactly one cycle.
      net_ready = 1'b1;
      send(3'd2); send(3'd3); send(3'd0);
      @(negedge clk);
      check("basic_valid", 32'(net_valid), 32'd1);
      check("basic_inp",   32'(net_inp),   32'h9);
      check("basic_err",   32'(err),       32'd0);
      @(negedge clk);
      check("basic_valid_drop", 32'(net_valid), 32'd0);

      // Empty packet.
      send(3'd0);
      @(negedge clk);
      check("empty_valid", 32'(net_valid), 32'd1);
      check("empty_inp",   32'(net_inp),   32'h0);
      @(negedge clk);
      check("empty_idle", 32'(src_ready), 32'd1);

      // Backpressure: the vector is held and no source word is accepted.
      net_ready = 1'b0;
      send(3'd1); send(3'd2);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_inp",   32'(net_inp),   32'h4);
         check("bp_ready", 32'(src_ready), 32'd0);
         check("bp_valid", 32'(net_valid), 32'd1);
      end
      net_ready = 1'b1;
      @(negedge clk);
      check("bp_release_ready", 32'(src_ready), 32'd1);
      check("bp_release_valid", 32'(net_valid), 32'd0);

      // Duplicate indices.
      send(3'd3); send(3'd1); send(3'd1); send(3'd2);
      @(negedge clk);
      check("dup_inp", 32'(net_inp), 32'h6);
      check("dup_err", 32'(err),     32'd0);

      // Oversized count and an out-of-range index.
      send(3'd6);
      @(negedge clk);
      check("viol_count_err", 32'(err), 32'd1);
      send(3'd5); send(3'd0); send(3'd0); send(3'd3);
      @(negedge clk);
      check("viol_inp",   32'(net_inp),   32'h9);
      check("viol_valid", 32'(net_valid), 32'd1);
      @(negedge clk);
      check("viol_err_sticky", 32'(err), 32'd1);
      pulse_clr();
      @(negedge clk);
      check("viol_err_clr", 32'(err), 32'd0);

      // Abort a packet with clr. The next word is taken as a count.
      send(3'd2); send(3'd1);
      pulse_clr();
      @(negedge clk);
      check("abort_inp",   32'(net_inp),   32'h0);
      check("abort_ready", 32'(src_ready), 32'd1);
      send(3'd1); send(3'd3);
      @(negedge clk);
      check("abort_next_inp", 32'(net_inp), 32'h8);

      // Asynchronous reset in the middle of a packet, with err set.
      @(negedge clk);
      send(3'd7); send(3'd1);
      #2 arstn = 1'b0;
      #1;
      check("arst_src_ready", 32'(src_ready), 32'd1);
      check("arst_net_valid", 32'(net_valid), 32'd0);
      check("arst_net_inp",   32'(net_inp),   32'd0);
      check("arst_err",       32'(err),       32'd0);
      @(negedge clk);
      arstn = 1'b1;
      send(3'd1); send(3'd0);
      @(negedge clk);
      check("post_rst_inp", 32'(net_inp), 32'h1);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
